bsr_scan_controller: RTL and testbench
======================================

# bsr_scan_controller

Drives a chain of boundary-scan cells (input and output `BoundaryScanRegister` cells linked `sout`→`sin`) from a parallel host interface. The sequence is: load a test vector into the chain, apply it to the core under test, capture the core's outputs, then shift the captured chain contents back out as a parallel result vector. It is the chain-side master that generates `shift`/`testing` and feeds `sin` / consumes `sout`. It sits between a test host (testbench or on-chip BIST sequencer) and the scan chain.

## Interface
- `CHAIN_LEN`, 16: number of cells in the chain, ≥2.
- `APPLY_CYCLES`, 1: cycles with `shift`=0 between load and unload, ≥1.
- `clock` in 1: single clock, shared with all chain cells.
- `reset` in 1: synchronous, active-high; same net drives the chain cells' reset.
- `start` in 1: request a scan session; sampled only in IDLE.
- `vec_in` in CHAIN_LEN: vector to load; bit p lands in chain position p (position 0 = cell fed by `scan_sin`).
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when `vec_out` is valid.
- `vec_out` out CHAIN_LEN: unloaded chain contents; bit p = position p; held until next `done`.
- `scan_sin` out 1: to `sin` of position 0.
- `scan_sout` in 1: from `sout` of position CHAIN_LEN-1.
- `scan_shift` out 1: chain `shift`.
- `scan_testing` out 1: chain `testing`.

## Operation
- States: IDLE, SHIFT_IN, APPLY, SHIFT_OUT, DONE.
- IDLE: all chain controls 0. `start`=1 latches `vec_in` into the load register, clears the counter, and moves to SHIFT_IN.
- SHIFT_IN: `scan_shift`=1, `scan_testing`=1. `scan_sin` = `vec_in[CHAIN_LEN-1-k]` on cycle k (MSB first). After CHAIN_LEN cycles, move to APPLY.
- APPLY: `scan_shift`=0, `scan_testing`=1 for APPLY_CYCLES cycles. Input cells hold their values; output cells capture core `din`. Then move to SHIFT_OUT.
- SHIFT_OUT: `scan_shift`=1, `scan_testing`=1, `scan_sin`=0. On cycle k, sample `scan_sout` into `vec_out[CHAIN_LEN-1-k]` at the same edge that shifts the chain. After CHAIN_LEN cycles, move to DONE.
- DONE: one cycle. `done`=1, `busy`=0, controls 0. Then return to IDLE.
- Counter width is `$clog2(CHAIN_LEN+1)`. The terminal count is CHAIN_LEN-1 (or APPLY_CYCLES-1) and is compared before the increment. There is no wrap inside a state.
- `start` while busy is ignored and not queued. `start` held high through DONE is taken in the next IDLE cycle.
- `vec_in` changes after acceptance have no effect.
- Reset values: state IDLE; `busy`, `done`, `scan_sin`, `scan_shift`, `scan_testing` = 0; `vec_out` = 0.
- Reset mid-session aborts immediately. The chain is reset by the same edge, and no `done` is produced.

## Timing
- `start` is accepted at edge 0. SHIFT_IN covers cycles 1..N, APPLY covers N+1..N+A, SHIFT_OUT covers N+A+1..2N+A, and `done` is high in cycle 2N+A+1 (N=CHAIN_LEN, A=APPLY_CYCLES).
- Start-to-done latency is 2N+A+1 cycles. The minimum start-to-start spacing is 2N+A+2 cycles.
- All outputs are registered. `scan_sin`, `scan_shift` and `scan_testing` are valid for the whole cycle in which the chain samples them.
- `vec_out` updates bit-by-bit during SHIFT_OUT. It is guaranteed complete only when `done`=1.

## Configuration
- `BSR_CTRL_COMPARE_EN` defined: adds these ports:
  - inputs `vec_exp` [CHAIN_LEN] and `vec_mask` [CHAIN_LEN], latched at `start`;
  - output `mismatch` = |((vec_out ^ vec_exp) & vec_mask), registered and valid with `done`, held until next `done`, reset 0.
- Undefined: those ports and the compare logic do not exist, and the behaviour is otherwise identical.

## Structure
- Package `bsr_ctrl_pkg`: state enum `bsr_ctrl_state_t` (IDLE, SHIFT_IN, APPLY, SHIFT_OUT, DONE) and a counter-width helper function.
- Sub-module `bsr_bit_counter`: a loadable up-counter with clear, enable and terminal-count compare, reused for the shift and apply phases.
- The FSM, load shift register and unload register live in the top module.

## Test plan
- Bench chain is 8 output cells, N=8, A=1, with core `din` tied to the complement of the first 8 input cells (16-cell mixed chain, N=16).
- N=8 all-output chain with `din`=8'hA5: `vec_in`=8'h00, start → `done` at cycle 18, `vec_out`=8'hA5.
- N=16 mixed chain: `vec_in` = 16'h00_3C in the input half → `vec_out` output half = 8'hC3 and input half = 8'h3C, `done` at cycle 34.
- Pulse `start` at cycles 0, 5 and 17 with N=8 → exactly one session and one `done` pulse; the second session is accepted only when `start` is reasserted in IDLE.
- Assert `reset` at cycle 10 of a session → cycle 11 shows all outputs 0 and state IDLE, no `done`; a new start completes normally.
- `BSR_CTRL_COMPARE_EN`, N=8, `din`=8'hA5:
  - `vec_exp`=8'hA4, `vec_mask`=8'h01 → `mismatch`=1;
  - `vec_mask`=8'hFE → `mismatch`=0.

Source files
------------

// File: rtl/bsr_ctrl_pkg.sv
// Shared types and helpers for the boundary-scan chain controller.
package bsr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    APPLY,
    SHIFT_OUT,
    DONE
  } bsr_ctrl_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsr_bit_counter.sv
// Up-counter with clear/enable and a terminal-count compare,
// shared by the shift and apply phases of the scan controller.
module bsr_bit_counter
  import bsr_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = 16,
  localparam int W = cnt_width(MAX_COUNT)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  assign at_term = (count == term);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bsr_scan_controller.sv
// Boundary-scan chain master: load, apply, capture, unload.
// Define BSR_CTRL_COMPARE_EN to add the masked expected-vector compare.
module bsr_scan_controller
  import bsr_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN    = 16,
  parameter int APPLY_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] vec_in,
`ifdef BSR_CTRL_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] vec_exp,
  input  logic [CHAIN_LEN-1:0] vec_mask,
  output logic                 mismatch,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] vec_out,
  output logic                 scan_sin,
  input  logic                 scan_sout,
  output logic                 scan_shift,
  output logic                 scan_testing
);

  localparam int MAXC =
    (CHAIN_LEN > APPLY_CYCLES) ? CHAIN_LEN : APPLY_CYCLES;
  localparam int CW = cnt_width(MAXC);

  bsr_ctrl_state_t state_q, state_n;

  logic [CW-1:0]        term;
  logic [CW-1:0]        count;
  logic                 at_term;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic                 take;
  logic [CHAIN_LEN-1:0] load_q;
  logic [CHAIN_LEN-1:0] vec_next;
  logic                 busy_n;
  logic                 done_n;
  logic                 shift_n;
  logic                 testing_n;

  assign take     = (state_q == IDLE) && start;
  assign cnt_en   = state_q inside {SHIFT_IN, APPLY, SHIFT_OUT};
  assign cnt_clr  = take || (cnt_en && at_term);
  assign term     = (state_q == APPLY) ? CW'(APPLY_CYCLES - 1)
                                       : CW'(CHAIN_LEN - 1);
  assign vec_next = {vec_out[CHAIN_LEN-2:0], scan_sout};

  // Load register empties as it shifts, so sin idles at 0.
  assign scan_sin = load_q[CHAIN_LEN-1];

  bsr_bit_counter #(
    .MAX_COUNT(MAXC)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .term   (term),
    .count  (count),
    .at_term(at_term)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:      if (start)   state_n = SHIFT_IN;
      SHIFT_IN:  if (at_term) state_n = APPLY;
      APPLY:     if (at_term) state_n = SHIFT_OUT;
      SHIFT_OUT: if (at_term) state_n = DONE;
      DONE:                   state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_n    = 1'b0;
    done_n    = 1'b0;
    shift_n   = 1'b0;
    testing_n = 1'b0;
    unique case (state_n)
      SHIFT_IN, SHIFT_OUT: begin
        busy_n    = 1'b1;
        shift_n   = 1'b1;
        testing_n = 1'b1;
      end
      APPLY: begin
        busy_n    = 1'b1;
        testing_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      scan_shift   <= 1'b0;
      scan_testing <= 1'b0;
      load_q       <= '0;
      vec_out      <= '0;
    end else begin
      busy         <= busy_n;
      done         <= done_n;
      scan_shift   <= shift_n;
      scan_testing <= testing_n;
      if (take)
        load_q <= vec_in;
      else if (state_q == SHIFT_IN)
        load_q <= load_q << 1;
      if (state_q == SHIFT_OUT)
        vec_out <= vec_next;
    end
  end

`ifdef BSR_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_q    <= '0;
      mask_q   <= '0;
      mismatch <= 1'b0;
    end else begin
      if (take) begin
        exp_q  <= vec_exp;
        mask_q <= vec_mask;
      end
      if (state_q == SHIFT_OUT && at_term)
        mismatch <= |((vec_next ^ exp_q) & mask_q);
    end
  end
`endif

endmodule

// File: tb/tb_bsr_scan_controller.sv
// Bench: 8-cell all-output chain and 16-cell mixed chain driven
// by two controller instances, with behavioural chain models.
module tb_bsr_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start8, start16;
  logic [7:0]  vin8;
  logic [15:0] vin16;
  logic        busy8, done8, sin8, sout8, shift8, test8;
  logic        busy16, done16, sin16, sout16, shift16, test16;
  logic [7:0]  vout8;
  logic [15:0] vout16;
`ifdef BSR_CTRL_COMPARE_EN
  logic [7:0]  exp8, mask8;
  logic [15:0] exp16, mask16;
  logic        mm8, mm16;
`endif

  bsr_scan_controller #(
    .CHAIN_LEN(8), .APPLY_CYCLES(1)
  ) dut8 (
    .clock(clk), .reset(reset), .start(start8),
    .vec_in(vin8),
`ifdef BSR_CTRL_COMPARE_EN
    .vec_exp(exp8), .vec_mask(mask8), .mismatch(mm8),
`endif
    .busy(busy8), .done(done8), .vec_out(vout8),
    .scan_sin(sin8), .scan_sout(sout8),
    .scan_shift(shift8), .scan_testing(test8)
  );

  bsr_scan_controller #(
    .CHAIN_LEN(16), .APPLY_CYCLES(1)
  ) dut16 (
    .clock(clk), .reset(reset), .start(start16),
    .vec_in(vin16),
`ifdef BSR_CTRL_COMPARE_EN
    .vec_exp(exp16), .vec_mask(mask16), .mismatch(mm16),
`endif
    .busy(busy16), .done(done16), .vec_out(vout16),
    .scan_sin(sin16), .scan_sout(sout16),
    .scan_shift(shift16), .scan_testing(test16)
  );

  // 8 output cells, core din = 8'hA5.
  logic [7:0] ch8;
  assign sout8 = ch8[7];
  always @(posedge clk) begin
    if (reset)      ch8 <= '0;
    else if (shift8) ch8 <= {ch8[6:0], sin8};
    else if (test8)  ch8 <= 8'hA5;
  end

  // Positions 0..7 input cells, 8..15 output cells (din = ~inputs).
  logic [15:0] ch16;
  assign sout16 = ch16[15];
  always @(posedge clk) begin
    if (reset)        ch16 <= '0;
    else if (shift16) ch16 <= {ch16[14:0], sin16};
    else if (test16)  ch16[15:8] <= ~ch16[7:0];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one session from a negedge in IDLE; ends on a negedge.
  task automatic run(input bit big,
                     input logic [15:0] v,
                     input logic [15:0] e,
                     input string tag);
    int n, lat, nsh, nap, nbusy;
    logic d, sh, te, bz;
    n = big ? 16 : 8;
    lat = 0; nsh = 0; nap = 0; nbusy = 0;
    if (big) begin vin16 = v; start16 = 1'b1; end
    else begin vin8 = v[7:0]; start8 = 1'b1; end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    vin16 = ~v; vin8 = ~v[7:0];
    for (int c = 1; c <= 80; c++) begin
      d  = big ? done16  : done8;
      sh = big ? shift16 : shift8;
      te = big ? test16  : test8;
      bz = big ? busy16  : busy8;
      if (d) begin lat = c; break; end
      if (bz) nbusy++;
      if (sh) nsh++;
      else if (te) nap++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, 2 * n + 2);
    chk({tag, " vec_out"},
        big ? {16'h0, vout16} : {24'h0, vout8}, {16'h0, e});
    chk({tag, " shift cycles"}, nsh, 2 * n);
    chk({tag, " apply cycles"}, nap, 1);
    chk({tag, " busy cycles"}, nbusy, 2 * n + 1);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(big ? done16 : done8), 0);
    chk({tag, " idle ctrl"},
        big ? 32'({busy16, shift16, test16, sin16})
            : 32'({busy8, shift8, test8, sin8}), 0);
  endtask

  typedef struct {
    bit          big;
    logic [15:0] v;
    logic [15:0] e;
  } vec_t;

  vec_t tbl[6];
  int   nd, at;

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 16'h00A5};
    tbl[1] = '{1'b0, 16'h00FF, 16'h00A5};
    tbl[2] = '{1'b1, 16'h003C, 16'hC33C};
    tbl[3] = '{1'b1, 16'h0000, 16'hFF00};
    tbl[4] = '{1'b1, 16'hFFA5, 16'h5AA5};
    tbl[5] = '{1'b1, 16'h1234, 16'hCB34};

    reset = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    vin8 = '0; vin16 = '0;
`ifdef BSR_CTRL_COMPARE_EN
    exp8 = '0; mask8 = '0; exp16 = '0; mask16 = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset dut8",
        32'({busy8, done8, sin8, shift8, test8, vout8}), 0);
    chk("reset dut16",
        32'({busy16, done16, sin16, shift16, test16, vout16}), 0);
`ifdef BSR_CTRL_COMPARE_EN
    chk("reset mismatch", 32'({mm8, mm16}), 0);
`endif

    for (int i = 0; i < 6; i++)
      run(tbl[i].big, tbl[i].v, tbl[i].e, $sformatf("vec%0d", i));

    // start at cycles 0, 5, 17: only the first is taken.
    vin8 = 8'h5A;
    nd = 0; at = 0;
    for (int c = 0; c <= 45; c++) begin
      if (done8) begin nd++; at = c; end
      start8 = (c == 0 || c == 5 || c == 17);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("pulse done count", nd, 1);
    chk("pulse done cycle", at, 18);
    chk("pulse not queued", 32'(busy8), 0);
    run(1'b0, 16'h0011, 16'h00A5, "restart");

    // reset at cycle 10 of a session aborts it.
    nd = 0;
    for (int c = 0; c <= 45; c++) begin
      if (c >= 11 && done8) nd++;
      if (c == 10) begin
        chk("pre-reset busy", 32'(busy8), 1);
        chk("pre-reset vec_out held", 32'(vout8), 32'hA5);
      end
      if (c == 11)
        chk("abort outputs",
            32'({busy8, done8, sin8, shift8, test8, vout8}), 0);
      start8 = (c == 0);
      reset  = (c == 10);
      @(negedge clk);
    end
    chk("abort no done", nd, 0);
    run(1'b0, 16'h003C, 16'h00A5, "post-reset");

`ifdef BSR_CTRL_COMPARE_EN
    exp8 = 8'hA4; mask8 = 8'h01;
    run(1'b0, 16'h0000, 16'h00A5, "cmp lsb");
    chk("mismatch lsb mask", 32'(mm8), 1);
    exp8 = 8'hA4; mask8 = 8'hFE;
    run(1'b0, 16'h0000, 16'h00A5, "cmp upper");
    chk("mismatch upper mask", 32'(mm8), 0);
    exp16 = 16'hC33C; mask16 = 16'hFFFF;
    run(1'b1, 16'h003C, 16'hC33C, "cmp16");
    chk("mismatch16 match", 32'(mm16), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
